// File: rtl/sdram_rd_collect.sv
// ---------------------------------------------------------------------------
// sdram_rd_collect
//
// Read-return collector that sits directly behind the SDRAM I/O block.
// Tagged read words are staged into a single assembly buffer. Each complete
// BURST-word burst is committed into one of four line registers, indexed by
// requester ID. Each line is then handed to its requester through a
// valid/ack handshake.
//
// Parameters
//   BURST  words per read burst (>= 2), equal to the SDRAM mode-register BL
//   DW     data word width
//
// Ports
//   clkSDRAM       in   SDRAM-domain clock; all state changes on its rising edge
//   reset          in   asynchronous, active-high reset
//   data_valid_io  in   a read word is present this cycle
//   data_id_io     in   requester ID (0..3) of the word
//   data_io        in   read word
//   line_valid     out  line[i] holds a complete, unacknowledged burst
//   line_data      out  line i at [i*BURST*DW +: BURST*DW]; word k at [k*DW +: DW]
//   line_ack       in   requester i consumes line i
//   err_trunc      out  one-cycle pulse: a partial burst was discarded
//   err_ovf        out  sticky: a burst completed for ID i while line i was occupied
//   err_clr        in   clears err_ovf
//
// Build option
//   SDRAM_RD_OVERWRITE_EN  when defined, an overflowing burst replaces the
//                          unacknowledged line (latest data wins). When
//                          undefined, the overflowing burst is dropped and
//                          the older line is kept. err_ovf is flagged in
//                          both builds.
// ---------------------------------------------------------------------------
module sdram_rd_collect #(
  parameter int BURST = 8,
  parameter int DW    = 16
) (
  input  logic                      clkSDRAM,
  input  logic                      reset,
  input  logic                      data_valid_io,
  input  logic [1:0]                data_id_io,
  input  logic [DW-1:0]             data_io,
  output logic [3:0]                line_valid,
  output logic [4*BURST*DW-1:0]     line_data,
  input  logic [3:0]                line_ack,
  output logic                      err_trunc,
  output logic [3:0]                err_ovf,
  input  logic                      err_clr
);

  localparam int            CW   = $clog2(BURST);
  localparam int            LW   = BURST * DW;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  // Staging state: words 0..BURST-2 of the burst being assembled
  logic [BURST-2:0][DW-1:0] r_stage;
  logic [CW-1:0]            r_cnt;
  logic [1:0]               r_cur_id;

  // Line registers and flags; these drive the outputs directly
  logic [3:0]               r_line_valid;
  logic [3:0][LW-1:0]       r_line_data;
  logic                     r_err_trunc;
  logic [3:0]               r_err_ovf;

  // Next-state values
  logic [BURST-2:0][DW-1:0] w_stage_n;
  logic [CW-1:0]            w_cnt_n;
  logic [1:0]               w_cur_id_n;
  logic [3:0]               w_line_valid_n;
  logic [3:0][LW-1:0]       w_line_data_n;
  logic [3:0]               w_ovf_set;
  logic [3:0]               w_ovf_n;

  logic                     w_match;
  logic                     w_trunc;
  logic                     w_commit;
  logic [LW-1:0]            w_new_line;

  // An empty stage accepts any ID; otherwise the word must continue the current burst
  assign w_match    = (r_cnt == {CW{1'b0}}) || (data_id_io == r_cur_id);
  assign w_trunc    = data_valid_io && !w_match;
  assign w_commit   = data_valid_io && w_match && (r_cnt == LAST);
  // The final word is not staged; it is spliced in as the top word of the line
  assign w_new_line = {data_io, r_stage};

  // Staging buffer, word counter and current-ID next state
  always_comb begin
    w_stage_n  = r_stage;
    w_cnt_n    = r_cnt;
    w_cur_id_n = r_cur_id;
    if (data_valid_io) begin
      w_cur_id_n = data_id_io;
      if (w_trunc) begin
        // The interrupting word restarts assembly as word 0 of its own burst
        w_stage_n[0] = data_io;
        w_cnt_n      = CW'(1);
      end else if (w_commit) begin
        w_cnt_n = {CW{1'b0}};
      end else begin
        for (int k = 0; k < BURST - 1; k++) begin
          if (r_cnt == CW'(k)) begin
            w_stage_n[k] = data_io;
          end else begin
            w_stage_n[k] = r_stage[k];
          end
        end
        w_cnt_n = r_cnt + CW'(1);
      end
    end else begin
      w_cnt_n = r_cnt;
    end
  end

  // Line registers, handshake and overflow detection next state
  always_comb begin
    w_line_valid_n = r_line_valid;
    w_line_data_n  = r_line_data;
    w_ovf_set      = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (w_commit && (data_id_io == 2'(i))) begin
        if (r_line_valid[i] && !line_ack[i]) begin
          w_ovf_set[i] = 1'b1;
`ifdef SDRAM_RD_OVERWRITE_EN
          w_line_data_n[i] = w_new_line;
`else
          w_line_data_n[i] = r_line_data[i];
`endif
        end else begin
          // Free line, or freed by an ack this very cycle
          w_line_data_n[i] = w_new_line;
        end
        w_line_valid_n[i] = 1'b1;
      end else if (line_ack[i] && r_line_valid[i]) begin
        // Data is retained after consumption; only the valid flag drops
        w_line_valid_n[i] = 1'b0;
      end else begin
        w_line_valid_n[i] = r_line_valid[i];
      end
    end
    // A new overflow in the same cycle as err_clr leaves its bit set
    w_ovf_n = (r_err_ovf & ~{4{err_clr}}) | w_ovf_set;
  end

  // State registers
  always_ff @(posedge clkSDRAM or posedge reset) begin
    if (reset) begin
      r_stage      <= '0;
      r_cnt        <= {CW{1'b0}};
      r_cur_id     <= 2'b00;
      r_line_valid <= 4'b0000;
      r_line_data  <= '0;
      r_err_trunc  <= 1'b0;
      r_err_ovf    <= 4'b0000;
    end else begin
      r_stage      <= w_stage_n;
      r_cnt        <= w_cnt_n;
      r_cur_id     <= w_cur_id_n;
      r_line_valid <= w_line_valid_n;
      r_line_data  <= w_line_data_n;
      r_err_trunc  <= w_trunc;
      r_err_ovf    <= w_ovf_n;
    end
  end

  assign line_valid = r_line_valid;
  assign line_data  = r_line_data;
  assign err_trunc  = r_err_trunc;
  assign err_ovf    = r_err_ovf;

endmodule

// File: tb/tb_sdram_rd_collect.sv
// ---------------------------------------------------------------------------
// tb_sdram_rd_collect
//
// Self-checking bench for sdram_rd_collect. A table of per-cycle vectors
// holds the inputs and the outputs expected just after the following rising
// edge. Hand-written sequences cover the err_clr/overflow collision and the
// reset-mid-burst case.
// ---------------------------------------------------------------------------
module tb_sdram_rd_collect;

  localparam int BURST = 8;
  localparam int DW    = 16;
  localparam int LW    = BURST * DW;

`ifdef SDRAM_RD_OVERWRITE_EN
  localparam logic [15:0] OVF_BASE1 = 16'h0020;
  localparam logic [15:0] OVF_BASE0 = 16'h0090;
`else
  localparam logic [15:0] OVF_BASE1 = 16'h0010;
  localparam logic [15:0] OVF_BASE0 = 16'h0070;
`endif

  logic                  clk;
  logic                  reset;
  logic                  data_valid_io;
  logic [1:0]            data_id_io;
  logic [DW-1:0]         data_io;
  logic [3:0]            line_valid;
  logic [4*LW-1:0]       line_data;
  logic [3:0]            line_ack;
  logic                  err_trunc;
  logic [3:0]            err_ovf;
  logic                  err_clr;

  int n_chk;
  int n_err;

  sdram_rd_collect #(.BURST(BURST), .DW(DW)) dut (
    .clkSDRAM      (clk),
    .reset         (reset),
    .data_valid_io (data_valid_io),
    .data_id_io    (data_id_io),
    .data_io       (data_io),
    .line_valid    (line_valid),
    .line_data     (line_data),
    .line_ack      (line_ack),
    .err_trunc     (err_trunc),
    .err_ovf       (err_ovf),
    .err_clr       (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  id;
    logic [15:0] d;
    logic [3:0]  ack;
    logic        clr;
    logic [3:0]  lv;
    logic        tr;
    logic [3:0]  ovf;
    logic        chk;
    logic [1:0]  cl;
    logic [15:0] base;
  } vec_t;

  vec_t tbl[$];

  function automatic void addv(input logic v, input logic [1:0] id, input logic [15:0] d,
                               input logic [3:0] ack, input logic clr, input logic [3:0] lv,
                               input logic tr, input logic [3:0] ovf, input logic chk,
                               input logic [1:0] cl, input logic [15:0] base);
    vec_t x;
    x.v = v; x.id = id; x.d = d; x.ack = ack; x.clr = clr;
    x.lv = lv; x.tr = tr; x.ovf = ovf; x.chk = chk; x.cl = cl; x.base = base;
    tbl.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_line(input int l, input logic [15:0] base);
    logic [15:0] w;
    for (int k = 0; k < BURST; k++) begin
      w = line_data[l*LW + k*DW +: DW];
      chk($sformatf("line%0d_w%0d", l, k), {16'h0000, w}, {16'h0000, 16'(base + 16'(k))});
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] id, input logic [15:0] d,
                       input logic [3:0] ack, input logic clr);
    data_valid_io = v;
    data_id_io    = id;
    data_io       = d;
    line_ack      = ack;
    err_clr       = clr;
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full burst for one ID, per-cycle check of err_trunc, optional ack/clr on the last word
  task automatic burst(input logic [1:0] id, input logic [15:0] base,
                       input logic [3:0] ack_last, input logic clr_last);
    for (int k = 0; k < BURST; k++) begin
      if (k == BURST - 1) drive(1'b1, id, 16'(base + 16'(k)), ack_last, clr_last);
      else                drive(1'b1, id, 16'(base + 16'(k)), 4'b0000, 1'b0);
      tick();
      chk($sformatf("burst_trunc_id%0d_w%0d", id, k), {31'd0, err_trunc}, 32'd0);
    end
    drive(1'b0, 2'b00, 16'h0000, 4'b0000, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    drive(1'b0, 2'b00, 16'h0000, 4'b0000, 1'b0);

    // Test 1: contiguous ID2 burst, then ack (data retained)
    for (int k = 0; k < 8; k++)
      addv(1'b1, 2'd2, 16'(16'h1000 + 16'(k)), 4'b0000, 1'b0,
           (k == 7) ? 4'b0100 : 4'b0000, 1'b0, 4'b0000, k == 7, 2'd2, 16'h1000);
    addv(1'b0, 2'd0, 16'h0000, 4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h1000);
    // Test 2: ID1 burst with a 3-cycle gap between words 3 and 4
    for (int k = 0; k < 8; k++) begin
      if (k == 4)
        for (int g = 0; g < 3; g++)
          addv(1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0000);
      addv(1'b1, 2'd1, 16'(16'h00A0 + 16'(k)), 4'b0000, 1'b0,
           (k == 7) ? 4'b0010 : 4'b0000, 1'b0, 4'b0000, k == 7, 2'd1, 16'h00A0);
    end
    addv(1'b0, 2'd0, 16'h0000, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0000);
    // ack on an empty line is ignored
    addv(1'b0, 2'd0, 16'h0000, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0000);
    // Test 3: 3 words ID0 truncated by an ID3 burst
    for (int k = 0; k < 3; k++)
      addv(1'b1, 2'd0, 16'(16'h0001 + 16'(k)), 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0000);
    for (int k = 0; k < 8; k++)
      addv(1'b1, 2'd3, 16'(16'h0030 + 16'(k)), 4'b0000, 1'b0,
           (k == 7) ? 4'b1000 : 4'b0000, k == 0, 4'b0000, k == 7, 2'd3, 16'h0030);
    // Test 5: second ID3 burst, acked on the commit cycle
    for (int k = 0; k < 8; k++)
      addv(1'b1, 2'd3, 16'(16'h0040 + 16'(k)), (k == 7) ? 4'b1000 : 4'b0000, 1'b0,
           4'b1000, 1'b0, 4'b0000, k == 7, 2'd3, 16'h0040);
    addv(1'b0, 2'd0, 16'h0000, 4'b1000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0000);
    // Test 4: two ID1 bursts without ack -> overflow, then err_clr, then ack
    for (int k = 0; k < 8; k++)
      addv(1'b1, 2'd1, 16'(16'h0010 + 16'(k)), 4'b0000, 1'b0,
           (k == 7) ? 4'b0010 : 4'b0000, 1'b0, 4'b0000, k == 7, 2'd1, 16'h0010);
    for (int k = 0; k < 8; k++)
      addv(1'b1, 2'd1, 16'(16'h0020 + 16'(k)), 4'b0000, 1'b0,
           4'b0010, 1'b0, (k == 7) ? 4'b0010 : 4'b0000, k == 7, 2'd1, OVF_BASE1);
    addv(1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0, 16'h0000);
    addv(1'b0, 2'd0, 16'h0000, 4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0000);
    addv(1'b0, 2'd0, 16'h0000, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, OVF_BASE1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_line_valid", {28'd0, line_valid}, 32'd0);
    chk("rst_err_trunc",  {31'd0, err_trunc}, 32'd0);
    chk("rst_err_ovf",    {28'd0, err_ovf}, 32'd0);
    chk("rst_line_data_nz", {31'd0, |line_data}, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].id, tbl[i].d, tbl[i].ack, tbl[i].clr);
      tick();
      chk($sformatf("v%0d_line_valid", i), {28'd0, line_valid}, {28'd0, tbl[i].lv});
      chk($sformatf("v%0d_err_trunc", i),  {31'd0, err_trunc},  {31'd0, tbl[i].tr});
      chk($sformatf("v%0d_err_ovf", i),    {28'd0, err_ovf},    {28'd0, tbl[i].ovf});
      if (tbl[i].chk) chk_line(int'(tbl[i].cl), tbl[i].base);
    end
    drive(1'b0, 2'b00, 16'h0000, 4'b0000, 1'b0);
    tick();
    // Earlier lines keep their data after consumption
    chk_line(2, 16'h1000);
    chk_line(3, 16'h0040);

    // err_clr colliding with a fresh overflow: the overflow wins
    burst(2'd0, 16'h0070, 4'b0000, 1'b0);
    chk("clr_a_line_valid", {28'd0, line_valid}, 32'h1);
    chk("clr_a_err_ovf",    {28'd0, err_ovf}, 32'h0);
    burst(2'd0, 16'h0080, 4'b0000, 1'b0);
    chk("clr_b_err_ovf",    {28'd0, err_ovf}, 32'h1);
    burst(2'd0, 16'h0090, 4'b0000, 1'b1);
    chk("clr_c_err_ovf",    {28'd0, err_ovf}, 32'h1);
    chk("clr_c_line_valid", {28'd0, line_valid}, 32'h1);
    chk_line(0, OVF_BASE0);
    drive(1'b0, 2'b00, 16'h0000, 4'b0000, 1'b1);
    tick();
    chk("clr_d_err_ovf",    {28'd0, err_ovf}, 32'h0);
    drive(1'b0, 2'b00, 16'h0000, 4'b0000, 1'b0);

    // Test 6: reset after 5 staged ID2 words, then a clean ID2 burst
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'd2, 16'(16'h0060 + 16'(k)), 4'b0000, 1'b0);
      tick();
    end
    drive(1'b0, 2'b00, 16'h0000, 4'b0000, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_line_valid", {28'd0, line_valid}, 32'd0);
    chk("mid_rst_line_data_nz", {31'd0, |line_data}, 32'd0);
    chk("mid_rst_err_trunc", {31'd0, err_trunc}, 32'd0);
    chk("mid_rst_err_ovf",   {28'd0, err_ovf}, 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < BURST; k++) begin
      drive(1'b1, 2'd2, 16'(16'h0050 + 16'(k)), 4'b0000, 1'b0);
      tick();
      chk($sformatf("post_rst_trunc_w%0d", k), {31'd0, err_trunc}, 32'd0);
      chk($sformatf("post_rst_line_valid_w%0d", k), {28'd0, line_valid},
          (k == BURST - 1) ? 32'h4 : 32'h0);
    end
    drive(1'b0, 2'b00, 16'h0000, 4'b0000, 1'b0);
    chk_line(2, 16'h0050);
    chk("post_rst_err_ovf", {28'd0, err_ovf}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
